fetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch FSM state and fetch queue entry type
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order prefetch FIFO with push/pop/clear and registered head
// Callers guarantee no push when full and no pop when empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    storage [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge Clk) begin
    if (push && !clear) storage[wptr] <= push_data;
  end

  assign head = storage[rptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, memory requests, prefetch queue, redirect flush
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc_plus1
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] resp_pc, resp_pc_nxt;
  logic [CW-1:0]     outstanding, outstanding_nxt;
  logic [CW-1:0]     discard, discard_nxt;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  assign occupancy = {1'b0, outstanding} + {1'b0, count};

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    discard_nxt     = discard;
    issue           = 1'b0;
    push            = imem_rvalid && (discard == '0) && !redirect;
    pop             = if_valid && !id_stall && !redirect;

    // Credit check uses registered occupancy only; a pop frees a slot next cycle.
    if (state == ST_FETCH && !redirect && occupancy < DEPTH_V) issue = 1'b1;

    outstanding_nxt = outstanding + CW'(issue) - CW'(imem_rvalid);
    if (issue) fetch_pc_nxt = fetch_pc + ADDR_W'(1);
    if (push)  resp_pc_nxt  = resp_pc + ADDR_W'(1);

    if (redirect) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_nxt = redirect_pc;
      resp_pc_nxt  = redirect_pc;
      discard_nxt  = outstanding - CW'(imem_rvalid);
      state_nxt    = (discard_nxt != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (imem_rvalid && discard != '0) discard_nxt = discard - CW'(1);
      if (state == ST_FLUSH && discard_nxt == '0) state_nxt = ST_FETCH;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  assign push_data.instr    = imem_rdata;
  assign push_data.pc_plus1 = resp_pc + ADDR_W'(1);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (push),
    .pop       (pop),
    .clear     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign imem_req    = issue && !Rst;
  assign imem_addr   = fetch_pc;
  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? head.instr    : '0;
  assign if_pc_plus1 = if_valid ? head.pc_plus1 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized bench for fetch_queue against a list-based fetch model
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus1;

  always #5 Clk = ~Clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus1 (if_pc_plus1)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [15:0] key;

  typedef struct {logic [15:0] addr; int due;} pend_t;
  typedef struct {logic [15:0] addr; bit stale;} infl_t;
  typedef struct {logic [15:0] instr; logic [15:0] pcp1;} ent_t;

  pend_t       mem_pend[$];
  infl_t       m_infl[$];
  ent_t        m_q[$];
  logic [15:0] m_pc;

  function automatic logic [15:0] memf(logic [15:0] a);
    return (a * 16'h9E37) ^ key;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_pend.size() > 0 && mem_pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_pend[0].addr);
      mem_pend.delete(0);
    end
  endtask

  task automatic apply_reset();
    Rst = 1'b1;
    redirect = 1'b0;
    id_stall = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    #1;
    chk("rst_imem_req", imem_req, 16'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", if_valid, 16'd0);
    chk("rst_if_instr", if_instr, 16'd0);
    chk("rst_if_pc_plus1", if_pc_plus1, 16'd0);
    m_pc = RESET_PC;
    m_infl.delete();
    m_q.delete();
    mem_pend.delete();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc = 0;
  endtask

  // One cycle: compare against the model mid-cycle, then advance model and memory across the edge.
  task automatic tick();
    bit   flushing, exp_req, exp_valid, pop_e, push_e;
    ent_t e_new;
    infl_t f;
    @(negedge Clk);
    flushing = 1'b0;
    foreach (m_infl[i]) if (m_infl[i].stale) flushing = 1'b1;
    exp_req   = !redirect && !flushing && (m_infl.size() + m_q.size() < DEPTH);
    exp_valid = m_q.size() > 0;
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, exp_valid);
    chk("if_instr", if_instr, exp_valid ? m_q[0].instr : 16'h0);
    chk("if_pc_plus1", if_pc_plus1, exp_valid ? m_q[0].pcp1 : 16'h0);

    pop_e  = exp_valid && !id_stall && !redirect;
    push_e = 1'b0;
    e_new  = '{16'h0, 16'h0};
    if (imem_rvalid && m_infl.size() > 0) begin
      f = m_infl.pop_front();
      if (!f.stale && !redirect) begin
        push_e      = 1'b1;
        e_new.instr = memf(f.addr);
        e_new.pcp1  = f.addr + 16'd1;
      end
    end
    if (redirect) begin
      m_q.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = redirect_pc;
    end else begin
      if (pop_e) void'(m_q.pop_front());
      if (push_e) m_q.push_back(e_new);
      if (exp_req) begin
        m_infl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 16'd1;
      end
    end
    if (imem_req) mem_pend.push_back('{imem_addr, cyc + lat});

    @(posedge Clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  initial begin
    int n;
    key = 16'($urandom);

    // Back-to-back fetch with single-cycle memory
    lat = 1;
    apply_reset();
    repeat (10) tick();

    // Decode stalled: queue fills, requests stop, then drain in order
    id_stall = 1'b1;
    repeat (8) tick();
    id_stall = 1'b0;
    repeat (10) tick();

    // Redirect with two requests in flight at latency 3
    lat = 3;
    apply_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    repeat (14) tick();

    // Redirect coinciding with a response and a dequeue
    lat = 2;
    apply_reset();
    n = 0;
    while (!(imem_rvalid && m_q.size() > 0) && n < 30) begin
      tick();
      n++;
    end
    chk("coincide_reached", 16'(n < 30), 16'd1);
    redirect = 1'b1;
    id_stall = 1'b0;
    redirect_pc = 16'h1234;
    tick();
    redirect = 1'b0;
    repeat (10) tick();

    // Address wrap through FFFF
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    repeat (10) tick();

    // Asynchronous reset mid-cycle while busy
    lat = 3;
    apply_reset();
    id_stall = 1'b1;
    repeat (5) tick();
    #2;
    apply_reset();
    repeat (8) tick();

    // Randomized stall/redirect traffic at several latencies
    for (int seg = 0; seg < 4; seg++) begin
      lat = $urandom_range(1, 4);
      apply_reset();
      for (int k = 0; k < 150; k++) begin
        id_stall = ($urandom_range(0, 9) < 3);
        redirect = ($urandom_range(0, 19) == 0);
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                  : 16'($urandom);
        tick();
      end
      redirect = 1'b0;
      id_stall = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
